extend_pipe: RTL and testbench
==============================

// Module: extend_pipe
// PURPOSE
// Parametrised, pipelined immediate-extension stage for the SIMD decode path; successor to the
// combinational extender. Accepts a raw 26-bit instruction immediate field and a 3-bit mode,
// and produces a scalar N-bit immediate plus a byte-broadcast vector immediate for the vector lanes.
// Outputs are registered in a 2-entry elastic buffer with valid/ready handshakes on both sides.
// A saturating counter tallies illegal modes.
// PARAMETERS
// N        32  scalar immediate width (>= 26)
// LANES    16  vector byte lanes; VecImm width = 8*LANES
// CNT_W    8   illegal-mode counter width
// PORTS
// clk        in   1          single clock, rising edge
// rst        in   1          synchronous reset, active-high
// in_valid   in   1          upstream has a request
// in_ready   out  1          buffer can accept (count < 2)
// A          in   26         raw immediate field
// ImmSrc     in   3          extension mode (imm_mode_t)
// out_valid  out  1          head entry valid (count > 0)
// out_ready  in   1          downstream accepts head
// ExtImm     out  N          scalar immediate of head entry
// VecImm     out  8*LANES    A[7:0] replicated LANES times (mode VBCAST), else 0
// out_illegal out 1          head entry had an illegal mode
// ill_count  out  CNT_W      saturating count of accepted illegal requests
// BEHAVIOUR
// - Modes, all widths zero-padded to N:
//   000 SEXT16 {A[15] x (N-16), A[15:0]}; 001 ZEXT26 {0, A[25:0]}; 010 UPPER {0, A[15:0], 16'b0}.
//   011 SHAMT {0, A[10:3]}; 100 VBCAST ExtImm = {0, A[7:0]}, VecImm = {LANES{A[7:0]}}.
//   101-111 illegal: ExtImm = all ones, VecImm = 0, out_illegal = 1.
// - Push = in_valid & in_ready; pop = out_valid & out_ready. Entries are computed at push and
//   stored. There is no combinational path from A to the outputs.
// - Latency: a push at edge k becomes visible on out_* after edge k (1 cycle) if the buffer was
//   empty. Order is strict FIFO.
// - in_ready = (count != 2), which depends only on registered state. No push when full. Push+pop
//   on the same edge with count = 1 leaves count = 1 and loads the new entry as head.
// - Push+pop with count = 2 is impossible because in_ready = 0. A pop alone at count = 2 gives
//   count = 1 and the second entry becomes head.
// - Empty: out_valid = 0, and ExtImm/VecImm/out_illegal hold their last values. The bench must
//   ignore them.
// - ill_count increments by 1 on each push with an illegal mode and saturates at 2^CNT_W-1
//   without wrapping. It is cleared only by rst.
// - Reset values: count = 0, out_valid = 0, in_ready = 1 (combinational from count), ExtImm = 0,
//   VecImm = 0, out_illegal = 0, ill_count = 0.
// - Reset mid-operation flushes both entries in the same edge. Any in_valid during rst is dropped.
// - Assertions: N >= 26. ImmSrc is not X when in_valid = 1.
// STRUCTURE
// - extend_pkg: imm_mode_t enum (SEXT16, ZEXT26, UPPER, SHAMT, VBCAST), IMM_FIELD_W = 26,
//   ILLEGAL_FILL constant.
// - Sub-module extend_core: purely combinational {A, ImmSrc} -> {ExtImm, VecImm, illegal}.
//   It is instantiated once, ahead of the buffer.
// - extend_pipe contains the 2-entry buffer (two entry regs, wr/rd pointer bits, count) and the
//   saturating counter.
// TESTING
// 1. Modes, N=32: A=26'h000_8001 SEXT16 -> ExtImm 32'hFFFF_8001; ZEXT26 A=26'h3FF_FFFF ->
//    32'h03FF_FFFF; UPPER A=16'h1234 -> 32'h1234_0000; SHAMT A[10:3]=8'hA5 -> 32'h0000_00A5.
// 2. VBCAST A[7:0]=8'h3C with LANES=16 -> VecImm 128'h3C3C...3C and ExtImm 32'h0000_003C.
//    Other modes give VecImm 0.
// 3. Backpressure: out_ready = 0, push 3 back-to-back. Third cycle in_ready = 0. Release
//    out_ready -> outputs appear in order, each exactly once, with no duplicates or drops.
// 4. Streaming: in_valid = out_ready = 1 for 20 cycles -> one result per cycle, 1-cycle
//    latency, count stays 1.
// 5. Illegal: ImmSrc=3'b101 pushed 300 times with CNT_W=8 -> ExtImm 32'hFFFF_FFFF,
//    out_illegal = 1, ill_count saturates at 255.
// 6. Reset with 2 entries held and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1,
//    ill_count = 0, and no stale entry is emitted afterwards.

Source files
------------

// File: rtl/extend_pkg.sv
// Shared types and constants for the immediate-extension pipeline.
package extend_pkg;

  localparam int IMM_FIELD_W = 26;
  localparam int MODE_W      = 3;

  // Extension modes; encodings 101..111 are illegal.
  typedef enum logic [MODE_W-1:0] {
    SEXT16 = 3'b000,
    ZEXT26 = 3'b001,
    UPPER  = 3'b010,
    SHAMT  = 3'b011,
    VBCAST = 3'b100
  } imm_mode_t;

  // Bit value replicated across the scalar immediate for an illegal mode.
  localparam logic ILLEGAL_FILL = 1'b1;

  // True for the five defined encodings.
  function automatic logic mode_is_legal(input logic [MODE_W-1:0] mode);
    return (mode <= MODE_W'(VBCAST));
  endfunction

endpackage

// File: rtl/extend_core.sv
// Combinational immediate extender: raw field + mode -> scalar and byte-broadcast vector.
module extend_core
  import extend_pkg::*;
#(
  parameter int N     = 32,
  parameter int LANES = 16
) (
  input  logic [IMM_FIELD_W-1:0] A,
  input  logic [MODE_W-1:0]      ImmSrc,
  output logic [N-1:0]           ExtImm,
  output logic [8*LANES-1:0]     VecImm,
  output logic                   illegal
);

  // Low byte of the field replicated into every lane.
  logic [8*LANES-1:0] bcast;

  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    assign bcast[8*gi +: 8] = A[7:0];
  end

  // Mode decode; unlisted encodings fall to the illegal fill.
  always_comb begin
    ExtImm  = '0;
    VecImm  = '0;
    illegal = !mode_is_legal(ImmSrc);
    case (ImmSrc)
      SEXT16: ExtImm = {{(N-16){A[15]}}, A[15:0]};
      ZEXT26: ExtImm[IMM_FIELD_W-1:0] = A;
      UPPER:  ExtImm = N'({A[15:0], 16'h0000});
      SHAMT:  ExtImm[7:0] = A[10:3];
      VBCAST: begin
        ExtImm[7:0] = A[7:0];
        VecImm      = bcast;
      end
      default: ExtImm = {N{ILLEGAL_FILL}};
    endcase
  end

endmodule

// File: rtl/extend_pipe.sv
// Pipelined immediate extender: extend at push, hold results in a 2-entry elastic FIFO,
// and count accepted illegal-mode requests with a saturating counter.
module extend_pipe
  import extend_pkg::*;
#(
  parameter int N     = 32,
  parameter int LANES = 16,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IMM_FIELD_W-1:0] A,
  input  logic [MODE_W-1:0]      ImmSrc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           ExtImm,
  output logic [8*LANES-1:0]     VecImm,
  output logic                   out_illegal,
  output logic [CNT_W-1:0]       ill_count
);

  localparam int                VEC_W   = 8*LANES;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [N-1:0]     core_ext;
  logic [VEC_W-1:0] core_vec;
  logic             core_ill;

  extend_core #(
    .N     (N),
    .LANES (LANES)
  ) u_core (
    .A       (A),
    .ImmSrc  (ImmSrc),
    .ExtImm  (core_ext),
    .VecImm  (core_vec),
    .illegal (core_ill)
  );

  logic [N-1:0]     ext_mem_reg [2];
  logic [VEC_W-1:0] vec_mem_reg [2];
  logic             ill_mem_reg [2];

  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic             rd_ptr_next;
  logic             out_sel_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic [CNT_W-1:0] ill_count_reg;
  logic             push;
  logic             pop;

  // Handshakes depend only on registered occupancy.
  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next occupancy and read pointer.
  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
    if (pop) begin
      rd_ptr_next = ~rd_ptr_reg;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage; results are computed once at push and stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        ext_mem_reg[i] <= '0;
        vec_mem_reg[i] <= '0;
        ill_mem_reg[i] <= 1'b0;
      end
    end else if (push) begin
      ext_mem_reg[wr_ptr_reg] <= core_ext;
      vec_mem_reg[wr_ptr_reg] <= core_vec;
      ill_mem_reg[wr_ptr_reg] <= core_ill;
    end
  end

  // Output select follows the head but freezes when the buffer drains, so the
  // outputs keep showing the last delivered entry. A push into an empty buffer
  // always lands in the other slot, so the frozen slot is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sel_reg <= 1'b0;
    end else if (count_next != 2'd0) begin
      out_sel_reg <= rd_ptr_next;
    end
  end

  // Saturating count of accepted illegal requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      ill_count_reg <= '0;
    end else if (push && core_ill && (ill_count_reg != CNT_MAX)) begin
      ill_count_reg <= ill_count_reg + 1'b1;
    end
  end

  assign ExtImm      = ext_mem_reg[out_sel_reg];
  assign VecImm      = vec_mem_reg[out_sel_reg];
  assign out_illegal = ill_mem_reg[out_sel_reg];
  assign ill_count   = ill_count_reg;

  a_width_ok: assert property (@(posedge clk) N >= IMM_FIELD_W);
  a_mode_known: assert property (@(posedge clk) disable iff (rst)
    in_valid |-> !$isunknown(ImmSrc));

endmodule

// File: tb/tb_extend_pipe.sv
// Directed self-checking bench for extend_pipe (N=32, LANES=16, CNT_W=8).
module tb_extend_pipe;

  localparam int N     = 32;
  localparam int LANES = 16;
  localparam int CNT_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [25:0]        A = '0;
  logic [2:0]         ImmSrc = 3'b000;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [N-1:0]       ExtImm;
  logic [8*LANES-1:0] VecImm;
  logic               out_illegal;
  logic [CNT_W-1:0]   ill_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  extend_pipe #(
    .N     (N),
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .ImmSrc      (ImmSrc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ExtImm      (ExtImm),
    .VecImm      (VecImm),
    .out_illegal (out_illegal),
    .ill_count   (ill_count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Push one request from an empty buffer and check the head one cycle later, then pop it.
  task automatic mode_vec(input string tag, input logic [25:0] a, input logic [2:0] mode,
                          input logic [31:0] exp_ext, input logic [127:0] exp_vec,
                          input logic exp_ill);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    A         = a;
    ImmSrc    = mode;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    $display("[TB] %s A=%h mode=%b -> ExtImm=%h ill=%b", tag, a, mode, ExtImm, out_illegal);
    check({tag, ".valid"}, 128'(out_valid), 128'(1'b1));
    check({tag, ".ext"}, 128'(ExtImm), 128'(exp_ext));
    check({tag, ".vec"}, VecImm, exp_vec);
    check({tag, ".ill"}, 128'(out_illegal), 128'(exp_ill));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] bc3c;
    int exp_cnt;
    bc3c = {16{8'h3C}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst.out_valid", 128'(out_valid), 128'(1'b0));
    check("rst.in_ready", 128'(in_ready), 128'(1'b1));
    check("rst.ext", 128'(ExtImm), 128'h0);
    check("rst.vec", VecImm, 128'h0);
    check("rst.ill", 128'(out_illegal), 128'(1'b0));
    check("rst.cnt", 128'(ill_count), 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Modes and broadcast
    mode_vec("sext16_neg", 26'h000_8001, 3'b000, 32'hFFFF_8001, 128'h0, 1'b0);
    mode_vec("sext16_pos", 26'h3FF_7FFF, 3'b000, 32'h0000_7FFF, 128'h0, 1'b0);
    mode_vec("zext26",     26'h3FF_FFFF, 3'b001, 32'h03FF_FFFF, 128'h0, 1'b0);
    mode_vec("upper",      26'h3C0_1234, 3'b010, 32'h1234_0000, 128'h0, 1'b0);
    mode_vec("shamt",      26'h3FF_F52F, 3'b011, 32'h0000_00A5, 128'h0, 1'b0);
    mode_vec("vbcast",     26'h2AB_CD3C, 3'b100, 32'h0000_003C, bc3c,   1'b0);
    mode_vec("illegal110", 26'h123_4567, 3'b110, 32'hFFFF_FFFF, 128'h0, 1'b1);
    @(negedge clk);
    check("ill.cnt1", 128'(ill_count), 128'd1);
    check("drain.valid", 128'(out_valid), 128'(1'b0));
    @(posedge clk); #1;

    // Backpressure: three back-to-back pushes against a stalled consumer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ImmSrc    = 3'b001;
    A         = 26'h11;
    @(negedge clk);
    check("bp.c0.in_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    A = 26'h22;
    @(negedge clk);
    $display("[TB] bp push 11 head=%h", ExtImm);
    check("bp.c1.ext", 128'(ExtImm), 128'h11);
    check("bp.c1.in_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    A = 26'h33;
    @(negedge clk);
    $display("[TB] bp push 22 in_ready=%b", in_ready);
    check("bp.c2.in_ready", 128'(in_ready), 128'(1'b0));
    check("bp.c2.ext", 128'(ExtImm), 128'h11);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.c3.ext", 128'(ExtImm), 128'h11);
    check("bp.c3.in_ready", 128'(in_ready), 128'(1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    $display("[TB] bp pop 11 head=%h", ExtImm);
    check("bp.c4.ext", 128'(ExtImm), 128'h22);
    check("bp.c4.valid", 128'(out_valid), 128'(1'b1));
    check("bp.c4.in_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    $display("[TB] bp pop 22 push 33 head=%h", ExtImm);
    check("bp.c5.ext", 128'(ExtImm), 128'h33);
    check("bp.c5.valid", 128'(out_valid), 128'(1'b1));
    @(posedge clk); #1;
    @(negedge clk);
    $display("[TB] bp pop 33");
    check("bp.c6.valid", 128'(out_valid), 128'(1'b0));
    @(posedge clk); #1;

    // Streaming: one result per cycle at 1-cycle latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ImmSrc    = 3'b001;
    for (int i = 0; i < 20; i++) begin
      A = 26'(32'h100 + i);
      @(posedge clk); #1;
      @(negedge clk);
      $display("[TB] stream %0d ExtImm=%h", i, ExtImm);
      check("stream.ext", 128'(ExtImm), 128'(32'h100 + i));
      check("stream.valid", 128'(out_valid), 128'(1'b1));
      check("stream.in_ready", 128'(in_ready), 128'(1'b1));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("stream.drain", 128'(out_valid), 128'(1'b0));

    // Illegal mode saturation (count is already 1)
    exp_cnt   = 1;
    in_valid  = 1'b1;
    ImmSrc    = 3'b101;
    A         = 26'h000_0042;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      @(negedge clk);
      if (i == 0 || i == 252 || i == 253 || i == 254 || i == 299) begin
        $display("[TB] illegal push %0d ill_count=%0d", i, ill_count);
        check("sat.cnt", 128'(ill_count), 128'(exp_cnt));
        check("sat.ext", 128'(ExtImm), 128'hFFFF_FFFF);
        check("sat.ill", 128'(out_illegal), 128'(1'b1));
        check("sat.vec", VecImm, 128'h0);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset while full with a request pending
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ImmSrc    = 3'b001;
    A         = 26'h0AA;
    @(posedge clk); #1;
    A = 26'h0BB;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst6.full", 128'(in_ready), 128'(1'b0));
    A   = 26'h055;
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    $display("[TB] reset mid-operation");
    check("rst6.valid", 128'(out_valid), 128'(1'b0));
    check("rst6.in_ready", 128'(in_ready), 128'(1'b1));
    check("rst6.cnt", 128'(ill_count), 128'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rst6.no_stale", 128'(out_valid), 128'(1'b0));
    end
    in_valid = 1'b1;
    A        = 26'h077;
    ImmSrc   = 3'b001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    $display("[TB] post-reset push 77 head=%h", ExtImm);
    check("rst6.fresh.ext", 128'(ExtImm), 128'h77);
    check("rst6.fresh.valid", 128'(out_valid), 128'(1'b1));
    @(posedge clk); #1;
    @(negedge clk);
    check("rst6.fresh.drain", 128'(out_valid), 128'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
